// File: rtl/quad_corner_tracker.sv
// Tracks the four extreme corners of a colour-keyed quadrilateral marker and
// publishes them once per frame. Optional feature macro: CORNER_SMOOTH_EN.
module quad_corner_tracker #(
    parameter logic [5:0]  CR_MIN   = 6'd40,
    parameter logic [5:0]  CR_MAX   = 6'd63,
    parameter logic [5:0]  CB_MIN   = 6'd0,
    parameter logic [5:0]  CB_MAX   = 6'd24,
    parameter logic [15:0] MIN_HITS = 16'd64
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        frame_flag,
    input  logic        pix_valid,
    input  logic [9:0]  pix_x,
    input  logic [8:0]  pix_y,
    input  logic [17:0] pix_ycrcb,
    output logic [9:0]  a_x,
    output logic [9:0]  b_x,
    output logic [9:0]  c_x,
    output logic [9:0]  d_x,
    output logic [8:0]  a_y,
    output logic [8:0]  b_y,
    output logic [8:0]  c_y,
    output logic [8:0]  d_y,
    output logic        corners_valid,
    output logic        corners_found
);

    localparam logic [5:0] CR_SPAN = CR_MAX - CR_MIN;
    localparam logic [5:0] CB_SPAN = CB_MAX - CB_MIN;

`ifdef CORNER_SMOOTH_EN
    function automatic logic [9:0] blend_x(input logic [9:0] old_v, input logic [9:0] new_v);
        logic [10:0] t;
        t = {1'b0, old_v} + {1'b0, new_v} + 11'd1;
        return t[10:1];
    endfunction

    function automatic logic [8:0] blend_y(input logic [8:0] old_v, input logic [8:0] new_v);
        logic [10:0] t;
        t = {2'b00, old_v} + {2'b00, new_v} + 11'd1;
        return t[9:1];
    endfunction
`endif

    // Offset-compare keeps the range test free of always-true halves when a bound is 0 or 63.
    logic [5:0] cr_off_s;
    logic [5:0] cb_off_s;
    logic       hit_s;
    assign cr_off_s = pix_ycrcb[11:6] - CR_MIN;
    assign cb_off_s = pix_ycrcb[5:0] - CB_MIN;
    assign hit_s    = pix_valid & (cr_off_s <= CR_SPAN) & (cb_off_s <= CB_SPAN);

    logic [9:0]  s1_x_q;
    logic [8:0]  s1_y_q;
    logic        s1_hit_q;
    logic        s1_flag_q;

    logic [9:0]  acc_ax_q, acc_bx_q, acc_cx_q, acc_dx_q;
    logic [8:0]  acc_ay_q, acc_by_q, acc_cy_q, acc_dy_q;
    logic [9:0]  acc_ax_d, acc_bx_d, acc_cx_d, acc_dx_d;
    logic [8:0]  acc_ay_d, acc_by_d, acc_cy_d, acc_dy_d;
    logic [15:0] hits_q, hits_d;

    logic [9:0]  ax_q, bx_q, cx_q, dx_q;
    logic [8:0]  ay_q, by_q, cy_q, dy_q;
    logic [9:0]  ax_d, bx_d, cx_d, dx_d;
    logic [8:0]  ay_d, by_d, cy_d, dy_d;
    logic        valid_q, valid_d;
    logic        found_q, found_d;

    logic [10:0] sum_s, diff_s;
    logic [10:0] a_sum_s, b_diff_s, c_sum_s, d_diff_s;
    logic        found_s;

    assign sum_s    = {1'b0, s1_x_q} + {2'b00, s1_y_q};
    assign diff_s   = {1'b0, s1_x_q} + (11'd511 - {2'b00, s1_y_q});
    assign a_sum_s  = {1'b0, acc_ax_q} + {2'b00, acc_ay_q};
    assign b_diff_s = {1'b0, acc_bx_q} + (11'd511 - {2'b00, acc_by_q});
    assign c_sum_s  = {1'b0, acc_cx_q} + {2'b00, acc_cy_q};
    assign d_diff_s = {1'b0, acc_dx_q} + (11'd511 - {2'b00, acc_dy_q});
    assign found_s  = (hits_q >= MIN_HITS);

    // Accumulate / publish next-state logic for the S2 stage.
    always_comb begin
        acc_ax_d = acc_ax_q; acc_ay_d = acc_ay_q;
        acc_bx_d = acc_bx_q; acc_by_d = acc_by_q;
        acc_cx_d = acc_cx_q; acc_cy_d = acc_cy_q;
        acc_dx_d = acc_dx_q; acc_dy_d = acc_dy_q;
        hits_d   = hits_q;
        ax_d = ax_q; ay_d = ay_q; bx_d = bx_q; by_d = by_q;
        cx_d = cx_q; cy_d = cy_q; dx_d = dx_q; dy_d = dy_q;
        valid_d  = 1'b0;
        found_d  = found_q;

        if (s1_flag_q) begin
            valid_d = 1'b1;
            found_d = found_s;
            if (found_s) begin
`ifdef CORNER_SMOOTH_EN
                ax_d = blend_x(ax_q, acc_ax_q); ay_d = blend_y(ay_q, acc_ay_q);
                bx_d = blend_x(bx_q, acc_bx_q); by_d = blend_y(by_q, acc_by_q);
                cx_d = blend_x(cx_q, acc_cx_q); cy_d = blend_y(cy_q, acc_cy_q);
                dx_d = blend_x(dx_q, acc_dx_q); dy_d = blend_y(dy_q, acc_dy_q);
`else
                ax_d = acc_ax_q; ay_d = acc_ay_q;
                bx_d = acc_bx_q; by_d = acc_by_q;
                cx_d = acc_cx_q; cy_d = acc_cy_q;
                dx_d = acc_dx_q; dy_d = acc_dy_q;
`endif
            end else begin
                ax_d = ax_q;
            end
            // A hit arriving with the flag seeds the next frame.
            if (s1_hit_q) begin
                acc_ax_d = s1_x_q; acc_ay_d = s1_y_q;
                acc_bx_d = s1_x_q; acc_by_d = s1_y_q;
                acc_cx_d = s1_x_q; acc_cy_d = s1_y_q;
                acc_dx_d = s1_x_q; acc_dy_d = s1_y_q;
                hits_d   = 16'd1;
            end else begin
                hits_d   = 16'd0;
            end
        end else if (s1_hit_q) begin
            if (hits_q == 16'd0) begin
                acc_ax_d = s1_x_q; acc_ay_d = s1_y_q;
                acc_bx_d = s1_x_q; acc_by_d = s1_y_q;
                acc_cx_d = s1_x_q; acc_cy_d = s1_y_q;
                acc_dx_d = s1_x_q; acc_dy_d = s1_y_q;
            end else begin
                if (sum_s < a_sum_s) begin
                    acc_ax_d = s1_x_q; acc_ay_d = s1_y_q;
                end else begin
                    acc_ax_d = acc_ax_q;
                end
                if (diff_s > b_diff_s) begin
                    acc_bx_d = s1_x_q; acc_by_d = s1_y_q;
                end else begin
                    acc_bx_d = acc_bx_q;
                end
                if (sum_s > c_sum_s) begin
                    acc_cx_d = s1_x_q; acc_cy_d = s1_y_q;
                end else begin
                    acc_cx_d = acc_cx_q;
                end
                if (diff_s < d_diff_s) begin
                    acc_dx_d = s1_x_q; acc_dy_d = s1_y_q;
                end else begin
                    acc_dx_d = acc_dx_q;
                end
            end
            if (hits_q != 16'hFFFF) begin
                hits_d = hits_q + 16'd1;
            end else begin
                hits_d = hits_q;
            end
        end else begin
            hits_d = hits_q;
        end
    end

    // Pipeline, accumulator and output registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            s1_x_q    <= 10'd0;
            s1_y_q    <= 9'd0;
            s1_hit_q  <= 1'b0;
            s1_flag_q <= 1'b0;
            acc_ax_q  <= 10'd0; acc_ay_q <= 9'd0;
            acc_bx_q  <= 10'd0; acc_by_q <= 9'd0;
            acc_cx_q  <= 10'd0; acc_cy_q <= 9'd0;
            acc_dx_q  <= 10'd0; acc_dy_q <= 9'd0;
            hits_q    <= 16'd0;
            ax_q      <= 10'd160; ay_q <= 9'd120;
            bx_q      <= 10'd480; by_q <= 9'd120;
            cx_q      <= 10'd480; cy_q <= 9'd360;
            dx_q      <= 10'd160; dy_q <= 9'd360;
            valid_q   <= 1'b0;
            found_q   <= 1'b0;
        end else begin
            s1_x_q    <= pix_x;
            s1_y_q    <= pix_y;
            s1_hit_q  <= hit_s;
            s1_flag_q <= frame_flag;
            acc_ax_q  <= acc_ax_d; acc_ay_q <= acc_ay_d;
            acc_bx_q  <= acc_bx_d; acc_by_q <= acc_by_d;
            acc_cx_q  <= acc_cx_d; acc_cy_q <= acc_cy_d;
            acc_dx_q  <= acc_dx_d; acc_dy_q <= acc_dy_d;
            hits_q    <= hits_d;
            ax_q      <= ax_d; ay_q <= ay_d;
            bx_q      <= bx_d; by_q <= by_d;
            cx_q      <= cx_d; cy_q <= cy_d;
            dx_q      <= dx_d; dy_q <= dy_d;
            valid_q   <= valid_d;
            found_q   <= found_d;
        end
    end

    assign a_x = ax_q; assign a_y = ay_q;
    assign b_x = bx_q; assign b_y = by_q;
    assign c_x = cx_q; assign c_y = cy_q;
    assign d_x = dx_q; assign d_y = dy_q;
    assign corners_valid = valid_q;
    assign corners_found = found_q;

endmodule

// File: tb/tb_quad_corner_tracker.sv
// Self-checking bench for quad_corner_tracker: directed scenarios plus random
// frames, compared every cycle against a frame-level reference model.
module tb_quad_corner_tracker;

    logic        clock = 1'b0;
    logic        reset, frame_flag, pix_valid;
    logic [9:0]  pix_x;
    logic [8:0]  pix_y;
    logic [17:0] pix_ycrcb;
    logic [9:0]  a_x, b_x, c_x, d_x;
    logic [8:0]  a_y, b_y, c_y, d_y;
    logic        corners_valid, corners_found;

    always #5 clock = ~clock;

    quad_corner_tracker dut (
        .clock(clock), .reset(reset), .frame_flag(frame_flag),
        .pix_valid(pix_valid), .pix_x(pix_x), .pix_y(pix_y), .pix_ycrcb(pix_ycrcb),
        .a_x(a_x), .b_x(b_x), .c_x(c_x), .d_x(d_x),
        .a_y(a_y), .b_y(b_y), .c_y(c_y), .d_y(d_y),
        .corners_valid(corners_valid), .corners_found(corners_found)
    );

    localparam logic [75:0] RESET_C = {10'd160, 9'd120, 10'd480, 9'd120,
                                       10'd480, 9'd360, 10'd160, 9'd360};

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: hits of the open frame, published state, and what the
    // outputs must show after the next clock edge.
    int          qx[$];
    int          qy[$];
    logic [75:0] m_c;
    bit          m_found;
    logic [75:0] p_c;
    bit          p_valid, p_found;

    logic [75:0] dut_c;
    assign dut_c = {a_x, a_y, b_x, b_y, c_x, c_y, d_x, d_y};

    function automatic bit is_marker(input logic [17:0] ycc);
        int cr, cb;
        cr = int'(ycc[11:6]);
        cb = int'(ycc[5:0]);
        return (cr >= 40) && (cr <= 63) && (cb >= 0) && (cb <= 24);
    endfunction

    function automatic logic [17:0] colour(input bit marker);
        logic [5:0] y, cr, cb;
        y = 6'($urandom_range(0, 63));
        if (marker) begin
            cr = 6'($urandom_range(40, 63));
            cb = 6'($urandom_range(0, 24));
        end else if ($urandom_range(0, 1) == 0) begin
            cr = 6'($urandom_range(0, 39));
            cb = 6'($urandom_range(0, 63));
        end else begin
            cr = 6'($urandom_range(0, 63));
            cb = 6'($urandom_range(25, 63));
        end
        return {y, cr, cb};
    endfunction

    // Extreme points of the frame; earliest wins ties because only strictly better replaces.
    function automatic logic [75:0] frame_corners();
        int ai = 0, bi = 0, ci = 0, di = 0;
        for (int i = 1; i < qx.size(); i++) begin
            if (qx[i] + qy[i] < qx[ai] + qy[ai]) ai = i;
            if (qx[i] - qy[i] > qx[bi] - qy[bi]) bi = i;
            if (qx[i] + qy[i] > qx[ci] + qy[ci]) ci = i;
            if (qx[i] - qy[i] < qx[di] - qy[di]) di = i;
        end
        return {10'(qx[ai]), 9'(qy[ai]), 10'(qx[bi]), 9'(qy[bi]),
                10'(qx[ci]), 9'(qy[ci]), 10'(qx[di]), 9'(qy[di])};
    endfunction

    function automatic int avg(input int o, input int n);
        return (o + n + 1) / 2;
    endfunction

    function automatic logic [75:0] publish(input logic [75:0] o, input logic [75:0] n);
`ifdef CORNER_SMOOTH_EN
        return {10'(avg(int'(o[75:66]), int'(n[75:66]))), 9'(avg(int'(o[65:57]), int'(n[65:57]))),
                10'(avg(int'(o[56:47]), int'(n[56:47]))), 9'(avg(int'(o[46:38]), int'(n[46:38]))),
                10'(avg(int'(o[37:28]), int'(n[37:28]))), 9'(avg(int'(o[27:19]), int'(n[27:19]))),
                10'(avg(int'(o[18:9]),  int'(n[18:9]))),  9'(avg(int'(o[8:0]),   int'(n[8:0])))};
`else
        return (o & 76'd0) | n;
`endif
    endfunction

    task automatic step(input bit rst, input bit flag, input bit vld,
                        input int x, input int y, input logic [17:0] ycc);
        bit          e_valid, e_found, hit;
        logic [75:0] e_c;
        reset = rst; frame_flag = flag; pix_valid = vld;
        pix_x = 10'(x); pix_y = 9'(y); pix_ycrcb = ycc;
        @(posedge clock);
        #1;
        if (rst) begin
            e_valid = 1'b0; e_found = 1'b0; e_c = RESET_C;
        end else begin
            e_valid = p_valid; e_found = p_found; e_c = p_c;
        end
        n_cmp++;
        assert (corners_valid === e_valid) else begin
            n_bad++;
            $error("FAIL valid t=%0t observed %0b expected %0b", $time, corners_valid, e_valid);
        end
        n_cmp++;
        assert (corners_found === e_found) else begin
            n_bad++;
            $error("FAIL found t=%0t observed %0b expected %0b", $time, corners_found, e_found);
        end
        n_cmp++;
        assert (dut_c === e_c) else begin
            n_bad++;
            $error("FAIL corners t=%0t observed %h expected %h", $time, dut_c, e_c);
        end
        if (rst) begin
            qx.delete(); qy.delete();
            m_c = RESET_C; m_found = 1'b0;
            p_valid = 1'b0; p_found = 1'b0; p_c = RESET_C;
        end else begin
            hit = vld && is_marker(ycc);
            if (flag) begin
                m_found = (qx.size() >= 64);
                if (m_found) m_c = publish(m_c, frame_corners());
                qx.delete(); qy.delete();
                p_valid = 1'b1;
            end else begin
                p_valid = 1'b0;
            end
            p_found = m_found;
            p_c = m_c;
            if (hit) begin
                qx.push_back(x); qy.push_back(y);
            end
        end
    endtask

    task automatic hit(input int x, input int y);
        step(1'b0, 1'b0, 1'b1, x, y, colour(1'b1));
    endtask

    task automatic noise();
        if ($urandom_range(0, 1) == 0)
            step(1'b0, 1'b0, 1'b1, $urandom_range(0, 639), $urandom_range(0, 479), colour(1'b0));
        else
            step(1'b0, 1'b0, 1'b0, $urandom_range(0, 639), $urandom_range(0, 479), colour(1'b1));
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 1'b0, 0, 0, 18'd0);
    endtask

    task automatic close_frame();
        step(1'b0, 1'b1, 1'b0, 0, 0, 18'd0);
        idle();
    endtask

    task automatic expect_c(input string tag, input logic [75:0] want);
        n_cmp++;
        assert (dut_c === want) else begin
            n_bad++;
            $error("FAIL %s observed %h expected %h", tag, dut_c, want);
        end
    endtask

    task automatic expect_bits(input string tag, input bit v, input bit f);
        n_cmp++;
        assert ({corners_valid, corners_found} === {v, f}) else begin
            n_bad++;
            $error("FAIL %s observed v=%0b f=%0b expected v=%0b f=%0b",
                   tag, corners_valid, corners_found, v, f);
        end
    endtask

    initial begin
        logic [75:0] square_c;
        logic [17:0] edge_col;
        int          len;
        square_c = {10'd200, 9'd100, 10'd299, 9'd100, 10'd299, 9'd199, 10'd200, 9'd199};

        // Reset state
        step(1'b1, 1'b0, 1'b0, 0, 0, 18'd0);
        step(1'b1, 1'b0, 1'b0, 0, 0, 18'd0);
        expect_c("reset_corners", RESET_C);
        expect_bits("reset_flags", 1'b0, 1'b0);

        // Square: corners first, then 96 edge points, with interleaved noise
        hit(200, 100); hit(299, 100); hit(299, 199); hit(200, 199);
        for (int i = 1; i <= 24; i++) begin
            hit(200 + 4 * i, 100);
            hit(299, 100 + 4 * i);
            if (i % 3 == 0) noise();
            hit(299 - 4 * i, 199);
            hit(200, 199 - 4 * i);
        end
        // Colour bounds just outside the key must not count
        edge_col = {6'd5, 6'd39, 6'd10};
        step(1'b0, 1'b0, 1'b1, 0, 0, edge_col);
        edge_col = {6'd5, 6'd50, 6'd25};
        step(1'b0, 1'b0, 1'b1, 639, 479, edge_col);
        edge_col = {6'd5, 6'd40, 6'd24};
        step(1'b0, 1'b0, 1'b1, 250, 150, edge_col);
        step(1'b0, 1'b1, 1'b0, 0, 0, 18'd0);
        idle();
        expect_bits("square_pulse", 1'b1, 1'b1);
`ifndef CORNER_SMOOTH_EN
        expect_c("square_corners", square_c);
`endif

        // Under threshold: outputs hold
        for (int i = 0; i < 10; i++) hit($urandom_range(0, 639), $urandom_range(0, 479));
        close_frame();
        expect_bits("under_pulse", 1'b1, 1'b0);
`ifndef CORNER_SMOOTH_EN
        expect_c("under_hold", square_c);
`endif

        // Boundary: 63 hits, then a hit with the flag belongs to the next frame
        for (int i = 0; i < 63; i++) hit($urandom_range(0, 639), $urandom_range(0, 479));
        step(1'b0, 1'b1, 1'b1, 639, 0, colour(1'b1));
        idle();
        expect_bits("boundary_excl", 1'b1, 1'b0);
        for (int i = 0; i < 63; i++) hit(639, 0);
        close_frame();
        expect_bits("boundary_next", 1'b1, 1'b1);
`ifndef CORNER_SMOOTH_EN
        expect_c("boundary_corners", {10'd639, 9'd0, 10'd639, 9'd0, 10'd639, 9'd0, 10'd639, 9'd0});
`endif

        // Tie on the sum key keeps the earliest pixel for A
        hit(300, 100); hit(200, 200);
        for (int i = 0; i < 62; i++) hit(400, 300);
        close_frame();
`ifndef CORNER_SMOOTH_EN
        n_cmp++;
        assert ({a_x, a_y} === {10'd300, 9'd100}) else begin
            n_bad++;
            $error("FAIL tie_a observed (%0d,%0d) expected (300,100)", a_x, a_y);
        end
`endif

        // Back-to-back flags each close a frame
        step(1'b0, 1'b1, 1'b0, 0, 0, 18'd0);
        step(1'b0, 1'b1, 1'b0, 0, 0, 18'd0);
        idle();
        idle();

        // Mid-operation reset drops an in-flight frame close
        for (int i = 0; i < 70; i++) hit($urandom_range(0, 639), $urandom_range(0, 479));
        step(1'b0, 1'b1, 1'b0, 0, 0, 18'd0);
        step(1'b1, 1'b0, 1'b0, 0, 0, 18'd0);
        idle();
        expect_bits("reset_nopulse", 1'b0, 1'b0);
        expect_c("reset_restore", RESET_C);

        // Random frames
        for (int f = 0; f < 16; f++) begin
            len = $urandom_range(30, 160);
            for (int i = 0; i < len; i++) begin
                if ($urandom_range(0, 9) < 7) hit($urandom_range(0, 639), $urandom_range(0, 479));
                else noise();
            end
            step(1'b0, 1'b1, $urandom_range(0, 1) == 1, $urandom_range(0, 639),
                 $urandom_range(0, 479), colour($urandom_range(0, 1) == 1));
            if ($urandom_range(0, 3) == 0) step(1'b0, 1'b1, 1'b0, 0, 0, 18'd0);
        end
        idle();
        idle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
